// File: rtl/bitstream_checker.sv
// PRBS-7 (x^7+x^6+1) receive checker: self-synchronises to a 4-bit-per-clock
// stream, then counts bit errors and checked symbols for link BER measurement.
module bitstream_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_THR = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       data_in,
  input  logic             data_valid,
  output logic             locked,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] sym_cnt,
  output logic             sym_err,
  output logic             lock_lost,
  output logic [1:0]       dbg_state
);

  // Input qualification: data_in is consumed only in cycles where data_valid=1.
  // There is no back-pressure; the checker accepts every valid symbol.

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0]       UNLOCK_N = 8'(UNLOCK_THR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nx;
  logic [6:0]       hist, hist_nx;
  logic [1:0]       nib_cnt, nib_nx;
  logic [7:0]       ok_cnt, ok_nx;
  logic [7:0]       bad_cnt, bad_nx;
  logic [CNT_W-1:0] bec_nx, sc_nx;
  logic             sym_err_nx, lock_lost_nx;

  logic [3:0]       pred;
  logic [6:0]       hist_pred, hist_data;
  logic [3:0]       err_bits;
  logic [2:0]       err_num;
  logic [CNT_W:0]   bec_sum;

  // Four recurrence steps unrolled; bit 3 is the earliest of the symbol.
  assign pred[3]   = hist[6] ^ hist[5];
  assign pred[2]   = hist[5] ^ hist[4];
  assign pred[1]   = hist[4] ^ hist[3];
  assign pred[0]   = hist[3] ^ hist[2];
  assign hist_pred = {hist[2:0], pred};
  assign hist_data = {hist[2:0], data_in};
  assign err_bits  = data_in ^ pred;
  assign err_num   = {2'b00, err_bits[0]} + {2'b00, err_bits[1]}
                   + {2'b00, err_bits[2]} + {2'b00, err_bits[3]};
  assign bec_sum   = {1'b0, bit_err_cnt} + {{(CNT_W-2){1'b0}}, err_num};

  always_comb begin
    state_nx     = state;
    hist_nx      = hist;
    nib_nx       = nib_cnt;
    ok_nx        = ok_cnt;
    bad_nx       = bad_cnt;
    bec_nx       = bit_err_cnt;
    sc_nx        = sym_cnt;
    sym_err_nx   = 1'b0;
    lock_lost_nx = 1'b0;
    if (data_valid) begin
      case (state)
        SEARCH: begin
          hist_nx = hist_data;
          nib_nx  = (nib_cnt == 2'd2) ? 2'd2 : nib_cnt + 2'd1;
          // An all-zero window is not a PRBS state; keep collecting.
          if (nib_nx == 2'd2 && hist_data != 7'd0) begin
            state_nx = VERIFY;
            ok_nx    = 8'd0;
          end
        end
        VERIFY: begin
          if (err_bits == 4'd0) begin
            hist_nx = hist_pred;
            ok_nx   = ok_cnt + 8'd1;
            if (ok_nx == LOCK_N) begin
              state_nx = LOCKED;
              bad_nx   = 8'd0;
            end
          end else begin
            state_nx = SEARCH;
            nib_nx   = 2'd0;
            hist_nx  = hist_data;
          end
        end
        LOCKED: begin
          // History follows the prediction so a corrupted symbol cannot
          // poison subsequent predictions.
          hist_nx = hist_pred;
          bec_nx  = bec_sum[CNT_W] ? CNT_MAX : bec_sum[CNT_W-1:0];
          sc_nx   = (sym_cnt == CNT_MAX) ? sym_cnt : sym_cnt + 1'b1;
          if (err_num != 3'd0) begin
            sym_err_nx = 1'b1;
            bad_nx     = bad_cnt + 8'd1;
            if (bad_nx == UNLOCK_N) begin
              state_nx     = SEARCH;
              nib_nx       = 2'd0;
              lock_lost_nx = 1'b1;
            end
          end else begin
            bad_nx = 8'd0;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      hist        <= 7'd0;
      nib_cnt     <= 2'd0;
      ok_cnt      <= 8'd0;
      bad_cnt     <= 8'd0;
      bit_err_cnt <= '0;
      sym_cnt     <= '0;
      sym_err     <= 1'b0;
      lock_lost   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nx;
      hist        <= hist_nx;
      nib_cnt     <= nib_nx;
      ok_cnt      <= ok_nx;
      bad_cnt     <= bad_nx;
      bit_err_cnt <= bec_nx;
      sym_cnt     <= sc_nx;
      sym_err     <= sym_err_nx;
      lock_lost   <= lock_lost_nx;
      locked      <= (state_nx == LOCKED);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bitstream_checker.sv
// Bench for bitstream_checker: a 16-bit and a 4-bit-counter instance share one
// input stream and are compared against a bit-level PRBS-7 reference model.
module tb_bitstream_checker;

  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_THR = 4;
  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  data_in = 4'd0;
  logic        data_valid = 1'b0;

  logic        locked, sym_err, lock_lost;
  logic [15:0] bit_err_cnt, sym_cnt;
  logic [1:0]  dbg_state;
  logic        locked4, sym_err4, lock_lost4;
  logic [3:0]  bit_err_cnt4, sym_cnt4;
  logic [1:0]  dbg_state4;
  logic [45:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  bitstream_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_THR(UNLOCK_THR), .CNT_W(16)) u16 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .locked(locked), .bit_err_cnt(bit_err_cnt), .sym_cnt(sym_cnt),
    .sym_err(sym_err), .lock_lost(lock_lost), .dbg_state(dbg_state));

  bitstream_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_THR(UNLOCK_THR), .CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .locked(locked4), .bit_err_cnt(bit_err_cnt4), .sym_cnt(sym_cnt4),
    .sym_err(sym_err4), .lock_lost(lock_lost4), .dbg_state(dbg_state4));

  assign dut_vec = {locked, sym_err, lock_lost, bit_err_cnt, sym_cnt,
                    locked4, sym_err4, lock_lost4, bit_err_cnt4, sym_cnt4};

  // ---------------- stream generator (bit list, oldest first) ----------------
  bit gen_q[$];

  task automatic gen_seed(input logic [6:0] s);
    gen_q.delete();
    for (int i = 6; i >= 0; i--) gen_q.push_back(s[i]);
  endtask

  function automatic logic [3:0] gen_sym();
    logic [3:0] s;
    bit nb;
    for (int k = 0; k < 4; k++) begin
      nb = gen_q[gen_q.size()-7] ^ gen_q[gen_q.size()-6];
      gen_q.push_back(nb);
      void'(gen_q.pop_front());
      s[3-k] = nb;
    end
    return s;
  endfunction

  // ---------------- reference model ----------------
  int     m_mode, m_nib, m_ok, m_bad;
  longint m_errs, m_syms;
  bit     m_sym_err, m_lost;
  bit     m_hist[$];

  task automatic model_reset();
    m_mode = M_SEARCH; m_nib = 0; m_ok = 0; m_bad = 0;
    m_errs = 0; m_syms = 0; m_sym_err = 0; m_lost = 0;
    m_hist.delete();
    for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
  endtask

  task automatic push_data(input logic [3:0] d);
    for (int k = 0; k < 4; k++) m_hist.push_back(d[3-k]);
    while (m_hist.size() > 7) void'(m_hist.pop_front());
  endtask

  task automatic model_step(input logic [3:0] d, input bit v);
    bit t[$];
    bit nb, any;
    int e;
    m_sym_err = 0;
    m_lost    = 0;
    if (v) begin
      if (m_mode == M_SEARCH) begin
        push_data(d);
        m_nib = (m_nib < 2) ? m_nib + 1 : 2;
        any = 0;
        foreach (m_hist[i]) any |= m_hist[i];
        if (m_nib == 2 && any) begin
          m_mode = M_VERIFY;
          m_ok   = 0;
        end
      end else begin
        t = m_hist;
        e = 0;
        for (int k = 0; k < 4; k++) begin
          nb = t[t.size()-7] ^ t[t.size()-6];
          t.push_back(nb);
          if (nb != d[3-k]) e++;
        end
        while (t.size() > 7) void'(t.pop_front());
        if (m_mode == M_VERIFY) begin
          if (e == 0) begin
            m_hist = t;
            m_ok++;
            if (m_ok == LOCK_CNT) begin
              m_mode = M_LOCKED;
              m_bad  = 0;
            end
          end else begin
            m_mode = M_SEARCH;
            m_nib  = 0;
            push_data(d);
          end
        end else begin
          m_hist = t;
          m_errs += e;
          m_syms += 1;
          if (e != 0) begin
            m_sym_err = 1;
            m_bad++;
            if (m_bad == UNLOCK_THR) begin
              m_mode = M_SEARCH;
              m_nib  = 0;
              m_lost = 1;
            end
          end else begin
            m_bad = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [15:0] sat16(input longint x);
    return (x > 65535) ? 16'hFFFF : 16'(x);
  endfunction

  function automatic logic [3:0] sat4(input longint x);
    return (x > 15) ? 4'hF : 4'(x);
  endfunction

  function automatic logic [45:0] exp_vec();
    bit lk;
    lk = (m_mode == M_LOCKED);
    return {lk, m_sym_err, m_lost, sat16(m_errs), sat16(m_syms),
            lk, m_sym_err, m_lost, sat4(m_errs), sat4(m_syms)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] d, input bit v);
    data_in    = d;
    data_valid = v;
    @(posedge clk);
    model_step(d, v);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    data_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
  endtask

  task automatic test_lock();
    logic [3:0] s;
    do_reset();
    gen_seed(7'h7F);
    for (int i = 0; i < 10; i++) begin
      send(gen_sym(), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL lock_acq sym %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_after_10: locked=%b expected 1", locked);
    end
    for (int i = 0; i < 5; i++) begin
      s = gen_sym();
      send(s, 1'b1);
    end
    checks++;
    if (sym_cnt !== 16'd5 || bit_err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL lock_counts: sym_cnt=%0d bit_err_cnt=%0d expected 5 and 0", sym_cnt, bit_err_cnt);
    end
  endtask

  task automatic test_single_error();
    send(gen_sym() ^ 4'b0100, 1'b1);
    checks++;
    if (sym_err !== 1'b1 || bit_err_cnt !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_err: sym_err=%b bit_err_cnt=%0d locked=%b expected 1,1,1",
               sym_err, bit_err_cnt, locked);
    end
    for (int i = 0; i < 6; i++) begin
      send(gen_sym(), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL single_err_after sym %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_burst_unlock();
    longint e0;
    e0 = m_errs;
    for (int i = 0; i < 4; i++) begin
      send(gen_sym() ^ 4'hF, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL burst sym %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (lock_lost !== 1'b1 || locked !== 1'b0 || bit_err_cnt !== sat16(e0 + 16)) begin
      errors++;
      $display("FAIL burst_unlock: lock_lost=%b locked=%b bit_err_cnt=%0d expected 1,0,%0d",
               lock_lost, locked, bit_err_cnt, sat16(e0 + 16));
    end
    for (int i = 0; i < 10; i++) begin
      send(gen_sym(), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL relock sym %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock_done: locked=%b expected 1", locked);
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(4'h0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL zeros sym %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b0 || bit_err_cnt !== 16'd0 || sym_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zeros_final: locked=%b bec=%0d sc=%0d expected 0,0,0", locked, bit_err_cnt, sym_cnt);
    end
  endtask

  task automatic test_verify_error();
    do_reset();
    gen_seed(7'($urandom_range(1, 127)));
    for (int i = 0; i < 16; i++) begin
      if (i == 5) send(gen_sym() ^ 4'($urandom_range(1, 15)), 1'b1);
      else        send(gen_sym(), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL verify_err sym %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1 || sym_cnt !== 16'd0 || bit_err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL verify_relock: locked=%b sc=%0d bec=%0d expected 1,0,0", locked, sym_cnt, bit_err_cnt);
    end
  endtask

  task automatic test_gaps();
    bit v;
    for (int i = 0; i < 80; i++) begin
      v = 1'($urandom_range(0, 1));
      send(v ? gen_sym() : 4'($urandom_range(0, 15)), v);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL gaps cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1 || bit_err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL gaps_final: locked=%b bec=%0d expected 1,0", locked, bit_err_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        send((k < 3) ? (gen_sym() ^ 4'hF) : gen_sym(), 1'b1);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL saturate r%0d k%0d: got %h expected %h", r, k, dut_vec, exp_vec());
        end
      end
    end
    checks++;
    if (bit_err_cnt4 !== 4'hF || sym_cnt4 !== 4'hF || locked !== 1'b1) begin
      errors++;
      $display("FAIL saturate_final: bec4=%0d sc4=%0d locked=%b expected 15,15,1",
               bit_err_cnt4, sym_cnt4, locked);
    end
  endtask

  task automatic test_reset_mid();
    reset      = 1'b1;
    data_in    = gen_sym() ^ 4'h3;
    data_valid = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    checks++;
    if (dut_vec !== 46'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", dut_vec);
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] s;
    do_reset();
    gen_seed(7'($urandom_range(1, 127)));
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        send(4'($urandom_range(0, 15)), 1'b0);
      end else begin
        s = gen_sym();
        if (r < 27) s = s ^ 4'($urandom_range(1, 15));
        send(s, 1'b1);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_single_error();
    test_burst_unlock();
    test_all_zero();
    test_verify_error();
    test_gaps();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
